sevenseg_scan_capture: RTL

Receive-side counterpart of the multiplexed seven-segment display port. The block samples the segment and digit-enable pins driven by a display driver, qualifies each digit once it is stable, and decodes the segment patterns back to hex nibbles. It assembles one nibble per digit position into a frame and hands the frame out over a valid/ready interface. It sits on the board-test side of the display bus, clocked from the 12 MHz board clock.

---
 rtl/sevenseg_scan_capture.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_capture.sv
// Receive-side capture for a multiplexed seven-segment display bus.
// Synchronizes the segment/digit pins, qualifies each digit once it has been
// stable for STABLE_CYCLES samples, decodes the pattern to a hex nibble and
// assembles one frame per full scan, handed out over valid/ready.
module sevenseg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk12,
    input  logic                    sys_rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   invalid_out,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

    // {invalid, blank, nibble} for a gfedcba pattern
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 6'h00;  7'h06: decode = 6'h01;
            7'h5B: decode = 6'h02;  7'h4F: decode = 6'h03;
            7'h66: decode = 6'h04;  7'h6D: decode = 6'h05;
            7'h7D: decode = 6'h06;  7'h07: decode = 6'h07;
            7'h7F: decode = 6'h08;  7'h6F: decode = 6'h09;
            7'h77: decode = 6'h0A;  7'h7C: decode = 6'h0B;
            7'h39: decode = 6'h0C;  7'h5E: decode = 6'h0D;
            7'h79: decode = 6'h0E;  7'h71: decode = 6'h0F;
            7'h00: decode = 6'h10;
            default: decode = 6'h20;
        endcase
    endfunction

    logic [6:0]            seg_m, seg_s;
    logic [NUM_DIGITS-1:0] en_m, en_s;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [6:0]            ref_seg_q, ref_seg_d;
    logic [NUM_DIGITS-1:0] ref_en_q, ref_en_d;
    logic                  capture;
    logic                  one_hot, same;

    logic [NUM_DIGITS-1:0][3:0] slot_q, slot_d;
    logic [NUM_DIGITS-1:0]      blank_q, blank_d, inval_q, inval_d;
    logic [NUM_DIGITS-1:0]      seen_q, seen_d;
    logic [IW-1:0]              cap_idx;
    logic [5:0]                 dec;
    logic                       frame_done, load, drop;

    // two-flop synchronizers on every pin
    always_ff @(posedge clk12 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seg_m <= '0;
            seg_s <= '0;
            en_m  <= '0;
            en_s  <= '0;
        end else begin
            seg_m <= seg_in;
            seg_s <= seg_m;
            en_m  <= en_in;
            en_s  <= en_m;
        end
    end

    assign one_hot = (en_s != '0) && ((en_s & (en_s - NUM_DIGITS'(1))) == '0);
    assign same    = (seg_s == ref_seg_q) && (en_s == ref_en_q);

    // qualifier state register with stability counter and reference value
    always_ff @(posedge clk12 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= WAIT;
            cnt_q     <= '0;
            ref_seg_q <= '0;
            ref_en_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_seg_q <= ref_seg_d;
            ref_en_q  <= ref_en_d;
        end
    end

    // qualifier next state: any non-one-hot enable aborts, a change re-arms
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_seg_d = ref_seg_q;
        ref_en_d  = ref_en_q;
        capture   = 1'b0;
        if (!one_hot) begin
            state_d = WAIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT: begin
                    state_d   = SETTLE;
                    cnt_d     = 8'd1;
                    ref_seg_d = seg_s;
                    ref_en_d  = en_s;
                end
                SETTLE: begin
                    if (!same) begin
                        cnt_d     = 8'd1;
                        ref_seg_d = seg_s;
                        ref_en_d  = en_s;
                    end else if (cnt_q == 8'(STABLE_CYCLES)) begin
                        capture = 1'b1;
                        state_d = HELD;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                HELD: begin
                    if (!same) begin
                        state_d   = SETTLE;
                        cnt_d     = 8'd1;
                        ref_seg_d = seg_s;
                        ref_en_d  = en_s;
                    end
                end
                default: state_d = WAIT;
            endcase
        end
    end

    assign dec = decode(ref_seg_q);

    // slot index of the qualified digit
    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (ref_en_q[i]) cap_idx = IW'(i);
    end

    // frame assembly: apply this cycle's capture, then decide load or drop
    always_comb begin
        slot_d  = slot_q;
        blank_d = blank_q;
        inval_d = inval_q;
        seen_d  = seen_q;
        if (capture) begin
            slot_d[cap_idx]  = dec[3:0];
            blank_d[cap_idx] = dec[4];
            inval_d[cap_idx] = dec[5];
            seen_d[cap_idx]  = 1'b1;
        end
    end

    assign frame_done = capture && (&seen_d);
    assign load       = frame_done && (!frame_valid || frame_ready);
    assign drop       = frame_done && frame_valid && !frame_ready;

    // slot storage and output frame register with valid/ready hold
    always_ff @(posedge clk12 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_q      <= '0;
            blank_q     <= '0;
            inval_q     <= '0;
            seen_q      <= '0;
            digits_out  <= '0;
            blank_out   <= '0;
            invalid_out <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            blank_q <= blank_d;
            inval_q <= inval_d;
            seen_q  <= frame_done ? '0 : seen_d;
            if (load) begin
                digits_out  <= slot_d;
                blank_out   <= blank_d;
                invalid_out <= inval_d;
            end
            frame_valid <= load | (frame_valid & ~frame_ready);
            overrun     <= drop;
        end
    end

endmodule
